// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, arbiter state encoding and index helpers
package regfile_pkg;
    localparam int RF_AW = 3;
    localparam int RF_DW = 8;
    localparam int IW = 2;
    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
    function automatic logic [3:0] idx2oh(input logic [IW-1:0] i);
        return 4'b0001 << i;
    endfunction
endpackage

// File: rtl/regwr_arbiter_if.sv
// regwr_arbiter_if: requester handshake plus registered register-file write command
interface regwr_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW = 3,
    parameter int DW = 8
);
    logic stall;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_last;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic wd;
    logic [AW-1:0] wdpick;
    logic [DW-1:0] data;
    logic [NREQ-1:0] owner;
    logic busy;
    modport master (
        output stall, req_valid, req_last, req_addr, req_data,
        input req_ready, wd, wdpick, data, owner, busy
    );
    modport slave (
        input stall, req_valid, req_last, req_addr, req_data,
        output req_ready, wd, wdpick, data, owner, busy
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick import regfile_pkg::*; #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    int j;
    logic [3:0] oh;
    // Scan farthest-first so the nearest request to ptr overwrites the rest
    always_comb begin
        idx = '0;
        j = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) idx = IW'(j);
        end
    end
    assign any = |req;
    assign oh = idx2oh(idx);
    assign gnt = any ? oh[NREQ-1:0] : '0;
endmodule

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: round-robin write-port arbiter with locked bursts and a registered
// write command for the register file
module regwr_arbiter import regfile_pkg::*; #(
    parameter int NREQ = 3,
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input logic CLK,
    input logic RST,
    regwr_arbiter_if.slave bus
);
    arb_state_t state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] own_idx;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] nxt_idx;
    logic [NREQ-1:0] pick_gnt;
    logic pick_any;
    logic xfer;
    logic [3:0] cur_oh;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req(bus.req_valid),
        .ptr(ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

    // In LOCK the owner is offered ready even while its valid is low
    assign bus.req_ready = bus.stall ? '0 : (state == ARB_LOCK) ? bus.owner : pick_gnt;
    assign cur_idx = (state == ARB_LOCK) ? own_idx : pick_idx;
    assign xfer = !bus.stall && ((state == ARB_LOCK) ? bus.req_valid[cur_idx] : pick_any);
    assign nxt_idx = (cur_idx == IW'(NREQ - 1)) ? '0 : cur_idx + 1'b1;
    assign cur_oh = idx2oh(cur_idx);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ARB_IDLE;
            ptr <= '0;
            own_idx <= '0;
            bus.wd <= 1'b0;
            bus.wdpick <= '0;
            bus.data <= '0;
            bus.owner <= '0;
            bus.busy <= 1'b0;
        end else begin
            bus.wd <= xfer;
            if (xfer) begin
                bus.wdpick <= bus.req_addr[int'(cur_idx)*AW +: AW];
                bus.data <= bus.req_data[int'(cur_idx)*DW +: DW];
                if (bus.req_last[cur_idx]) begin
                    state <= ARB_IDLE;
                    ptr <= nxt_idx;
                    bus.owner <= '0;
                    bus.busy <= 1'b0;
                end else begin
                    state <= ARB_LOCK;
                    own_idx <= cur_idx;
                    bus.owner <= cur_oh[NREQ-1:0];
                    bus.busy <= 1'b1;
                end
            end
        end
    end
endmodule
